// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect,
// and the decode-side valid/ready instruction channel.
//   master : the fetch stage (drives imem request and the instruction channel)
//   slave  : the environment (memory, execute, decode)
interface if_fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, op, funct3, funct7,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, op, funct3, funct7,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           inst_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage. Holds the PC, issues word-aligned fetch requests,
// buffers returned words in a 2-entry queue and presents them (with PC and
// pre-sliced op/funct3/funct7) to decode over valid/ready. A redirect flushes
// the queue and discards responses to requests still in flight.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : if_fetch_stage_if.master (imem req/rsp, redirect, instruction channel)
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  if_fetch_stage_if.master bus
);

  logic [31:0] fetch_pc_q;
  logic [31:0] resp_pc_q;
  logic [1:0]  outstanding_q;
  logic [1:0]  drop_q;
  logic [1:0]  count_q;
  logic        head_q;
  logic [31:0] q_pc_q   [2];
  logic [31:0] q_inst_q [2];

  logic        inst_valid;
  logic        pop;
  logic        push;
  logic        req_valid;
  logic        req_fire;
  logic        tail;
  logic [2:0]  credit_sum;
  logic [31:0] redirect_aligned;

  always_comb begin
    inst_valid       = !rst && (count_q != 2'd0);
    pop              = inst_valid && bus.inst_ready;
    // Budget covers both buffered entries and responses still in flight, so a
    // response always has a free slot and memory never needs backpressure.
    credit_sum       = {1'b0, outstanding_q} + {1'b0, count_q} - {2'b00, pop};
    req_valid        = !rst && !bus.redirect_valid && (credit_sum < 3'd2);
    req_fire         = req_valid && bus.imem_req_ready;
    push             = bus.imem_rsp_valid && (drop_q == 2'd0);
    tail             = head_q ^ count_q[0];
    redirect_aligned = {bus.redirect_pc[31:2], 2'b00};
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.inst_valid     = inst_valid;
  // Head entry is not touched until the next push, so outputs hold when empty.
  assign bus.inst           = q_inst_q[head_q];
  assign bus.inst_pc        = q_pc_q[head_q];
  assign bus.op             = q_inst_q[head_q][6:0];
  assign bus.funct3         = q_inst_q[head_q][14:12];
  assign bus.funct7         = q_inst_q[head_q][31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
    end else if (bus.redirect_valid) begin
      // No request is issued this cycle; a response landing now is discarded,
      // and every other in-flight response must be dropped when it arrives.
      fetch_pc_q    <= redirect_aligned;
      resp_pc_q     <= redirect_aligned;
      count_q       <= 2'd0;
      drop_q        <= outstanding_q - {1'b0, bus.imem_rsp_valid};
      outstanding_q <= outstanding_q - {1'b0, bus.imem_rsp_valid};
    end else begin
      if (req_fire) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
      outstanding_q <= outstanding_q + {1'b0, req_fire} - {1'b0, bus.imem_rsp_valid};
      if (bus.imem_rsp_valid) begin
        if (drop_q != 2'd0) begin
          drop_q <= drop_q - 2'd1;
        end else begin
          q_pc_q[tail]   <= resp_pc_q;
          q_inst_q[tail] <= bus.imem_rsp_data;
          resp_pc_q      <= resp_pc_q + 32'd4;
        end
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      head_q  <= head_q ^ pop;
    end
  end

endmodule
